// File: rtl/dma_utils_pkg.sv
// Shared DMA typedefs, defaults and small helpers.
`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 16
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

package dma_utils_pkg;

    // Occupancy/count type for the default-depth DMA FIFO (one extra bit to hold "full").
    typedef logic [$clog2(`DMA_FIFO_DEPTH):0] dma_fifo_cnt_t;

    // Registered head stage is the default: it keeps RAM read paths off the consumer timing.
    localparam int DMA_FIFO_OUT_REG_DEF = 1;

    function automatic logic is_pow2_ge2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/dma_fifo_ram.sv
// Storage array for the DMA FIFO: one synchronous write port, one asynchronous read port.
module dma_fifo_ram
    import dma_utils_pkg::*;
#(
    parameter int SLOTS = 16,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [SLOTS];

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dma_fifo_hs.sv
// DMA staging FIFO with valid/ready on both sides, optional registered head stage,
// almost-full/almost-empty flags and a high-water-mark counter.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

module dma_fifo_hs
    import dma_utils_pkg::*;
#(
    parameter int SLOTS   = 16,
    parameter int WIDTH   = `DMA_DATA_WIDTH,
    parameter int OUT_REG = DMA_FIFO_OUT_REG_DEF,
    parameter int AW      = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic [AW:0]      afull_thr_i,
    input  logic [AW:0]      aempty_thr_i,
    output logic             afull_o,
    output logic             aempty_o,
    output logic [AW:0]      ocup_o,
    output logic [AW:0]      free_o,
    output logic [AW:0]      hwm_o
);

    localparam int          CW      = AW + 1;
    localparam logic [AW:0] SLOTS_C = CW'(SLOTS);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      ocup_q, ocup_d, hwm_q, hwm_d;
    logic             push, pop, ram_we, rd_adv, ram_empty;
    logic             head_valid;
    logic [WIDTH-1:0] head_data, ram_rdata;

    assign ram_empty  = (wr_ptr_q == rd_ptr_q);
    assign in_ready_o = (ocup_q < SLOTS_C);
    assign push       = in_valid_i & in_ready_o;
    assign pop        = out_valid_o & out_ready_i;

    dma_fifo_ram #(
        .SLOTS (SLOTS),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (in_data_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    generate
        if (OUT_REG != 0) begin : g_head_reg
            logic             head_valid_q, head_valid_d;
            logic [WIDTH-1:0] head_data_q, head_data_d;

            // Head register: bypass-load when empty, refill from RAM on pop, otherwise push to RAM.
            always_comb begin
                head_valid_d = head_valid_q;
                head_data_d  = head_data_q;
                ram_we       = 1'b0;
                rd_adv       = 1'b0;
                if (clear_i) begin
                    head_valid_d = 1'b0;
                    head_data_d  = '0;
                end else if (!head_valid_q) begin
                    if (push) begin
                        head_valid_d = 1'b1;
                        head_data_d  = in_data_i;
                    end
                end else if (pop) begin
                    if (!ram_empty) begin
                        head_data_d = ram_rdata;
                        rd_adv      = 1'b1;
                        ram_we      = push;
                    end else if (push) begin
                        head_data_d = in_data_i;
                    end else begin
                        head_valid_d = 1'b0;
                    end
                end else begin
                    ram_we = push;
                end
            end

            // Head register state.
            always_ff @(posedge clk) begin
                if (rst) begin
                    head_valid_q <= 1'b0;
                    head_data_q  <= '0;
                end else begin
                    head_valid_q <= head_valid_d;
                    head_data_q  <= head_data_d;
                end
            end

            assign head_valid = head_valid_q;
            assign head_data  = head_data_q;
        end else begin : g_head_comb
            // Head is simply the RAM entry at the read pointer.
            assign ram_we     = push & ~clear_i;
            assign rd_adv     = pop & ~clear_i;
            assign head_valid = ~ram_empty;
            assign head_data  = ram_rdata;
        end
    endgenerate

    // Pointer, occupancy and high-water-mark next state; a flush overrides any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, ram_we};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_adv};
        ocup_d   = ocup_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        hwm_d    = (ocup_d > hwm_q) ? ocup_d : hwm_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ocup_d   = '0;
            hwm_d    = '0;
        end
    end

    // Pointer, occupancy and high-water-mark registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ocup_q   <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ocup_q   <= ocup_d;
            hwm_q    <= hwm_d;
        end
    end

    assign out_valid_o = head_valid;
    assign out_data_o  = head_valid ? head_data : '0;
    assign ocup_o      = ocup_q;
    assign hwm_o       = hwm_q;
    assign free_o      = SLOTS_C - ocup_q;
    assign afull_o     = (ocup_q >= afull_thr_i);
    assign aempty_o    = (ocup_q <= aempty_thr_i);

`ifndef NO_ASSERTIONS
    a_slots_pow2: assert property (@(posedge clk) is_pow2_ge2(SLOTS));
    a_ocup_max:   assert property (@(posedge clk) disable iff (rst) ocup_o <= SLOTS_C);
    a_data_hold:  assert property (@(posedge clk) disable iff (rst)
                      (out_valid_o && !out_ready_i && !clear_i) |=> $stable(out_data_o));
`endif

endmodule

// File: tb/tb_dma_fifo_hs.sv
// Scoreboard bench for dma_fifo_hs: drives both head-stage variants with identical stimulus.
module tb_dma_fifo_hs;

    localparam int SLOTS = 4;
    localparam int W     = 8;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, out_ready;
    logic [7:0] in_data;
    logic [2:0] afull_thr, aempty_thr;

    logic       ir [2];
    logic       ov [2];
    logic [7:0] od [2];
    logic       af [2];
    logic       ae [2];
    logic [2:0] oc [2];
    logic [2:0] fr [2];
    logic [2:0] hw [2];

    logic [W-1:0] sbq [2][$];
    int           hwm_m [2];
    int           npop [2];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           verbose  = 1'b1;

    always #5 clk = ~clk;

    dma_fifo_hs #(.SLOTS(SLOTS), .WIDTH(W), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(ir[0]), .in_data_i(in_data),
        .out_valid_o(ov[0]), .out_ready_i(out_ready), .out_data_o(od[0]),
        .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
        .afull_o(af[0]), .aempty_o(ae[0]), .ocup_o(oc[0]), .free_o(fr[0]), .hwm_o(hw[0])
    );

    dma_fifo_hs #(.SLOTS(SLOTS), .WIDTH(W), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(ir[1]), .in_data_i(in_data),
        .out_valid_o(ov[1]), .out_ready_i(out_ready), .out_data_o(od[1]),
        .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
        .afull_o(af[1]), .aempty_o(ae[1]), .ocup_o(oc[1]), .free_o(fr[1]), .hwm_o(hw[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: scoreboard bookkeeping on the falling edge, state checks just after the rising edge.
    task automatic step();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst || clear) begin
                sbq[m].delete();
                hwm_m[m] = 0;
            end else begin
                if (ov[m] && out_ready) begin
                    if (sbq[m].size() == 0) begin
                        check($sformatf("m%0d_pop_on_empty", m), 1, 0);
                    end else begin
                        logic [W-1:0] exp_d;
                        exp_d = sbq[m].pop_front();
                        check($sformatf("m%0d_rd_data", m), od[m], exp_d);
                        npop[m]++;
                        if (verbose) $display("m%0d pop  data=%02h", m, od[m]);
                    end
                end
                if (in_valid && ir[m]) begin
                    sbq[m].push_back(in_data);
                    if (verbose) $display("m%0d push data=%02h", m, in_data);
                end
                if (sbq[m].size() > hwm_m[m]) hwm_m[m] = sbq[m].size();
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            int sz;
            sz = sbq[m].size();
            check($sformatf("m%0d_ocup", m), oc[m], sz);
            check($sformatf("m%0d_free", m), fr[m], SLOTS - sz);
            check($sformatf("m%0d_hwm", m), hw[m], hwm_m[m]);
            check($sformatf("m%0d_in_ready", m), ir[m], sz < SLOTS);
            check($sformatf("m%0d_out_valid", m), ov[m], sz != 0);
            check($sformatf("m%0d_head", m), od[m], (sz != 0) ? sbq[m][0] : 8'h00);
            check($sformatf("m%0d_afull", m), af[m], sz >= int'(afull_thr));
            check($sformatf("m%0d_aempty", m), ae[m], sz <= int'(aempty_thr));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 8'(i), 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        afull_thr = 3'd3; aempty_thr = 3'd1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_rst_ocup", m), oc[m], 0);
            check($sformatf("m%0d_rst_ready", m), ir[m], 1);
            check($sformatf("m%0d_rst_valid", m), ov[m], 0);
            check($sformatf("m%0d_rst_data", m), od[m], 0);
        end

        // Fill to capacity with the consumer stalled, then drain.
        fill(4, 8'hA0);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_full_ready", m), ir[m], 0);
            check($sformatf("m%0d_full_ocup", m), oc[m], 4);
            check($sformatf("m%0d_full_free", m), fr[m], 0);
            check($sformatf("m%0d_full_hwm", m), hw[m], 4);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            step();
        end
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_drain_ocup", m), oc[m], 0);
            check($sformatf("m%0d_drain_hwm", m), hw[m], 4);
            check($sformatf("m%0d_drain_pops", m), npop[m], 4);
        end

        // Streaming: 64 words, one per cycle after the first.
        do_clear();
        npop[0] = 0; npop[1] = 0;
        for (int k = 0; k < 65; k++) begin
            drive(k < 64, 8'(k), 1'b1);
            step();
            for (int m = 0; m < 2; m++)
                check($sformatf("m%0d_stream_ocup_bound", m), oc[m] <= ((m == 0) ? 3'd1 : 3'd2), 1);
        end
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_stream_pops", m), npop[m], 64);
            check($sformatf("m%0d_stream_ocup", m), oc[m], 0);
        end

        // Full with push and pop in the same cycle: only the pop happens.
        fill(4, 8'hB0);
        drive(1'b1, 8'h55, 1'b1);
        step();
        for (int m = 0; m < 2; m++) check($sformatf("m%0d_fullrw_ocup", m), oc[m], 3);
        drive(1'b1, 8'h66, 1'b0);
        step();
        for (int m = 0; m < 2; m++) check($sformatf("m%0d_fullrw_next_push", m), oc[m], 4);

        // Threshold flags across fill 0..4, then an out-of-range afull threshold.
        do_clear();
        afull_thr = 3'd3; aempty_thr = 3'd1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_lvl0_aempty", m), ae[m], 1);
            check($sformatf("m%0d_lvl0_afull", m), af[m], 0);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 8'hC0 + 8'(k), 1'b0);
            step();
            for (int m = 0; m < 2; m++) begin
                check($sformatf("m%0d_lvl%0d_aempty", m, k), ae[m], k <= 1);
                check($sformatf("m%0d_lvl%0d_afull", m, k), af[m], k >= 3);
            end
        end
        afull_thr = 3'd5;
        drive(1'b0, 8'h00, 1'b0);
        step();
        for (int m = 0; m < 2; m++) check($sformatf("m%0d_thr5_afull", m), af[m], 0);
        afull_thr = 3'd3;

        // Flush with both handshakes active: clear_i, then rst.
        for (int pass = 0; pass < 2; pass++) begin
            do_clear();
            fill(3, 8'hD0);
            if (pass == 0) clear = 1'b1; else rst = 1'b1;
            drive(1'b1, 8'hEE, 1'b1);
            step();
            clear = 1'b0; rst = 1'b0;
            drive(1'b0, 8'h00, 1'b0);
            for (int m = 0; m < 2; m++) begin
                check($sformatf("m%0d_flush%0d_ocup", m, pass), oc[m], 0);
                check($sformatf("m%0d_flush%0d_hwm", m, pass), hw[m], 0);
                check($sformatf("m%0d_flush%0d_valid", m, pass), ov[m], 0);
                check($sformatf("m%0d_flush%0d_data", m, pass), od[m], 0);
                check($sformatf("m%0d_flush%0d_ready", m, pass), ir[m], 1);
            end
        end

        // Random traffic against the scoreboard.
        verbose = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            if (k % 1000 == 0) begin
                afull_thr  = 3'($urandom_range(0, 5));
                aempty_thr = 3'($urandom_range(0, 5));
            end
            clear = ($urandom_range(0, 499) == 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            step();
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
